soc_io_bridge: RTL and testbench
================================

# soc_io_bridge

Memory-mapped bus bridge between the single-cycle CPU's data port and the rest of the SoC. It decodes each data access, routes stores either to data RAM or to peripheral registers, and returns load data through a combinational read mux. It also owns the on-board peripherals' sequential logic: LED latch, 8-digit 7-segment scanner, input synchronisers and a prescaled millisecond timer.

## Interface
- SCAN_DIV, 20000: cpu_clk cycles each 7-segment digit stays lit (≥2).
- TIMER_DIV, 25000: cpu_clk cycles per timer increment (≥1).
- cpu_clk  in  1  system clock; all state updates on rising edge.
- cpu_rst  in  1  reset, synchronous, active-low (0 = reset, sampled on cpu_clk rising edge).
- addr_from_cpu  in  32  byte address of current data access.
- wen_from_cpu  in  1  store strobe; one write per cycle while high.
- wdata_from_cpu  in  32  store data.
- rdata_to_cpu  out  32  load data, combinational.
- dram_addr  out  14  word address = addr_from_cpu[15:2].
- dram_we  out  1  data-RAM write enable.
- dram_wdata  out  32  = wdata_from_cpu.
- dram_rdata  in  32  data-RAM asynchronous read data.
- sw  in  24  raw switches.
- button  in  5  raw push buttons.
- led  out  24  LED drive, active-high.
- dig_en  out  8  digit enables, active-low, one-hot-zero.
- seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.

## Operation
- Decode: addr[31:12] == 20'hFFFFF → IO space; else DRAM.
- IO map (word-aligned, addr[11:0]): 0x000 DIGITS (R/W, 32 bit, 8 nibbles, nibble i → digit i); 0x020 TIMER (R/W); 0x060 LED (R/W, low 24 bits); 0x070 SWITCH (R, 24 bits zero-extended); 0x078 BUTTON (R, 5 bits zero-extended). Any other IO address: reads 0, writes ignored.
- dram_we = wen_from_cpu & DRAM-space. IO writes never assert dram_we.
- rdata_to_cpu: dram_rdata for DRAM space; selected register for IO space. Reads carry no side effects.
- Synchronisers: sw and button each pass through two flops; SWITCH/BUTTON return second-stage value.
- Timer: prescaler counts 0..TIMER_DIV-1; on terminal count prescaler → 0 and TIMER += 1 (32-bit, wraps 0xFFFFFFFF → 0). CPU write to TIMER loads wdata and clears prescaler; write wins over simultaneous tick.
- Scanner: scan counter 0..SCAN_DIV-1; on terminal count digit index (3 bit) advances, 7 → 0. dig_en = ~(1 << index). seg = hex-to-7-seg of DIGITS nibble[index], DP always off (bit 7 = 1). Glyph set 0-9, A, b, C, d, E, F; e.g. 0 → 8'hC0, 8 → 8'h80, F → 8'h8E.
- seg and dig_en are registered: both update on the same edge, no ghosting between digits.

## Timing
- Reset (cpu_rst=0 at edge): DIGITS=0, TIMER=0, LED=0, prescaler=0, scan counter=0, index=0, sync flops=0. Next-cycle outputs: led=0, dig_en=8'hFE, seg=8'hC0. rdata_to_cpu stays combinational (DRAM data passes through during reset).
- Reset mid-operation overrides any same-cycle write or tick.
- Store: register visible on rdata_to_cpu from the cycle after the write edge; led changes the cycle after the edge.
- Display change: new DIGITS value appears on seg no later than the next scan step (≤ SCAN_DIV+1 cycles for the current digit).
- Input latency: sw/button change visible to loads 2 cycles after the change is sampled.
- Timer: first increment TIMER_DIV cycles after reset release or TIMER write.
- dram_we, dram_addr, dram_wdata: purely combinational, zero latency.

## Test plan
- Reset: hold cpu_rst=0 for 3 cycles, release → led=0, dig_en=8'hFE, seg=8'hC0, TIMER read=0.
- DRAM vs IO decode: store 0x12345678 to 0x0000_0100 → dram_we=1, dram_addr=0x040. Store to 0xFFFF_F060 → dram_we=0, led=0x345678 next cycle. Read 0xFFFF_F044 → 0.
- Scanner (SCAN_DIV=4): write DIGITS=0x0000_00F8 → index 0 seg=8'h80, after 4 cycles dig_en=8'hFD seg=8'h8E; after 32 cycles back to dig_en=8'hFE.
- Timer (TIMER_DIV=3): after reset, TIMER reads 1 at cycle 3, 2 at cycle 6. Write 0xFFFFFFFF → reads 0 three cycles later. Write coinciding with a tick loads the written value.
- Inputs: drive sw=0xABCDEF → SWITCH read returns 0x00ABCDEF from the second cycle after. button=5'b10001 → BUTTON read=0x11.

Source files
------------

// File: rtl/soc_io_bridge.sv
// rtl/soc_io_bridge.sv - CPU data-port bridge: DRAM/IO decode, LED, 7-seg scanner, input sync, timer
module soc_io_bridge #(
  parameter int SCAN_DIV  = 20000,
  parameter int TIMER_DIV = 25000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] addr_from_cpu,
  input  logic        wen_from_cpu,
  input  logic [31:0] wdata_from_cpu,
  output logic [31:0] rdata_to_cpu,
  output logic [13:0] dram_addr,
  output logic        dram_we,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  localparam logic [TW-1:0] PRESC_MAX = TW'(TIMER_DIV - 1);
  localparam logic [TW-1:0] PRESC_ONE = TW'(1);

  localparam logic [11:0] OFF_DIGITS = 12'h000;
  localparam logic [11:0] OFF_TIMER  = 12'h020;
  localparam logic [11:0] OFF_LED    = 12'h060;
  localparam logic [11:0] OFF_SWITCH = 12'h070;
  localparam logic [11:0] OFF_BUTTON = 12'h078;

  logic [31:0]   r_digits;
  logic [31:0]   r_timer;
  logic [23:0]   r_led;
  logic [TW-1:0] r_presc;
  logic [SW-1:0] r_scan_cnt;
  logic [2:0]    r_index;
  logic [23:0]   r_sw_s1, r_sw_s2;
  logic [4:0]    r_btn_s1, r_btn_s2;
  logic [7:0]    r_dig_en;
  logic [7:0]    r_seg;

  logic          w_io;
  logic [11:0]   w_off;
  logic          w_wr_io;
  logic          w_wr_digits, w_wr_timer, w_wr_led;
  logic          w_scan_tick, w_timer_tick;
  logic [2:0]    w_idx_nxt;
  logic [3:0]    w_nibble;

  function automatic logic [7:0] f_glyph(input logic [3:0] n);
    case (n)
      4'h0: f_glyph = 8'hC0;
      4'h1: f_glyph = 8'hF9;
      4'h2: f_glyph = 8'hA4;
      4'h3: f_glyph = 8'hB0;
      4'h4: f_glyph = 8'h99;
      4'h5: f_glyph = 8'h92;
      4'h6: f_glyph = 8'h82;
      4'h7: f_glyph = 8'hF8;
      4'h8: f_glyph = 8'h80;
      4'h9: f_glyph = 8'h90;
      4'hA: f_glyph = 8'h88;
      4'hB: f_glyph = 8'h83;
      4'hC: f_glyph = 8'hC6;
      4'hD: f_glyph = 8'hA1;
      4'hE: f_glyph = 8'h86;
      default: f_glyph = 8'h8E;
    endcase
  endfunction

  assign w_io        = (addr_from_cpu[31:12] == 20'hFFFFF);
  assign w_off       = addr_from_cpu[11:0];
  assign w_wr_io     = wen_from_cpu & w_io;
  assign w_wr_digits = w_wr_io & (w_off == OFF_DIGITS);
  assign w_wr_timer  = w_wr_io & (w_off == OFF_TIMER);
  assign w_wr_led    = w_wr_io & (w_off == OFF_LED);

  assign dram_addr  = addr_from_cpu[15:2];
  assign dram_we    = wen_from_cpu & ~w_io;
  assign dram_wdata = wdata_from_cpu;

  assign w_scan_tick  = (r_scan_cnt == SCAN_MAX);
  assign w_timer_tick = (r_presc == PRESC_MAX);
  assign w_idx_nxt    = w_scan_tick ? r_index + 3'd1 : r_index;
  // Look up the glyph for the digit about to be lit so seg and dig_en move together.
  assign w_nibble     = r_digits[{w_idx_nxt, 2'b00} +: 4];

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      r_digits   <= '0;
      r_timer    <= '0;
      r_led      <= '0;
      r_presc    <= '0;
      r_scan_cnt <= '0;
      r_index    <= '0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_dig_en   <= 8'hFE;
      r_seg      <= 8'hC0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= button;
      r_btn_s2 <= r_btn_s1;

      r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + SCAN_ONE;
      r_index    <= w_idx_nxt;
      r_dig_en   <= ~(8'b1 << w_idx_nxt);
      r_seg      <= f_glyph(w_nibble);

      if (w_wr_timer) begin
        r_timer <= wdata_from_cpu;
        r_presc <= '0;
      end else if (w_timer_tick) begin
        r_timer <= r_timer + 32'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PRESC_ONE;
      end

      if (w_wr_digits) r_digits <= wdata_from_cpu;
      if (w_wr_led)    r_led    <= wdata_from_cpu[23:0];
    end
  end

  always_comb begin
    rdata_to_cpu = '0;
    if (!w_io) begin
      rdata_to_cpu = dram_rdata;
    end else begin
      case (w_off)
        OFF_DIGITS: rdata_to_cpu = r_digits;
        OFF_TIMER:  rdata_to_cpu = r_timer;
        OFF_LED:    rdata_to_cpu = {8'h00, r_led};
        OFF_SWITCH: rdata_to_cpu = {8'h00, r_sw_s2};
        OFF_BUTTON: rdata_to_cpu = {27'h0, r_btn_s2};
        default:    rdata_to_cpu = '0;
      endcase
    end
  end

  assign led    = r_led;
  assign dig_en = r_dig_en;
  assign seg    = r_seg;

endmodule

// File: tb/tb_soc_io_bridge.sv
// tb/tb_soc_io_bridge.sv - scoreboard bench for soc_io_bridge against an arithmetic reference model
module tb_soc_io_bridge;

  localparam int SCAN_DIV  = 4;
  localparam int TIMER_DIV = 3;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] addr_from_cpu;
  logic        wen_from_cpu;
  logic [31:0] wdata_from_cpu;
  logic [31:0] rdata_to_cpu;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [4:0]  button;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  soc_io_bridge #(.SCAN_DIV(SCAN_DIV), .TIMER_DIV(TIMER_DIV)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .addr_from_cpu(addr_from_cpu), .wen_from_cpu(wen_from_cpu), .wdata_from_cpu(wdata_from_cpu),
    .rdata_to_cpu(rdata_to_cpu),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw(sw), .button(button), .led(led), .dig_en(dig_en), .seg(seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: timer is base + elapsed/TIMER_DIV, scan index from elapsed edges.
  logic [31:0] m_digits, m_led32, m_timer_base;
  int          m_timer_k, m_scan_k;
  logic [23:0] m_sw1, m_sw2;
  logic [4:0]  m_btn1, m_btn2;
  logic [7:0]  m_dig_en, m_seg;

  function automatic logic [31:0] model_timer();
    return m_timer_base + 32'(m_timer_k / TIMER_DIV);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] dr);
    logic [19:0] hi;
    logic [11:0] off;
    hi  = a[31:12];
    off = a[11:0];
    if (hi != 20'hFFFFF) return dr;
    case (off)
      12'h000: return m_digits;
      12'h020: return model_timer();
      12'h060: return {8'h00, m_led32[23:0]};
      12'h070: return {8'h00, m_sw2};
      12'h078: return {27'h0, m_btn2};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return rdata_to_cpu;
      1: return {8'h00, led};
      2: return {24'h0, dig_en};
      3: return {24'h0, seg};
      4: return {31'h0, dram_we};
      5: return {18'h0, dram_addr};
      default: return dram_wdata;
    endcase
  endfunction

  always @(negedge cpu_clk) begin
    logic [31:0] act;
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = actual(e.sel);
      n_checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_err++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", e.name, e.cyc, act, e.exp);
      end
    end
  end

  task automatic model_edge();
    logic [31:0] seg_src;
    logic        io_wr;
    logic [11:0] off;
    int          idx;
    int          nib;
    io_wr = wen_from_cpu && (addr_from_cpu[31:12] == 20'hFFFFF);
    off   = addr_from_cpu[11:0];
    if (!cpu_rst) begin
      seg_src = 32'h0;
      m_digits = 0; m_led32 = 0; m_timer_base = 0; m_timer_k = 0; m_scan_k = 0;
      m_sw1 = 0; m_sw2 = 0; m_btn1 = 0; m_btn2 = 0;
    end else begin
      seg_src = m_digits;
      m_sw2 = m_sw1;   m_sw1 = sw;
      m_btn2 = m_btn1; m_btn1 = button;
      m_scan_k++;
      if (io_wr && off == 12'h020) begin
        m_timer_base = wdata_from_cpu;
        m_timer_k = 0;
      end else begin
        m_timer_k++;
      end
      if (io_wr && off == 12'h000) m_digits = wdata_from_cpu;
      if (io_wr && off == 12'h060) m_led32 = {8'h00, wdata_from_cpu[23:0]};
    end
    idx = (m_scan_k / SCAN_DIV) % 8;
    nib = int'((seg_src >> (4 * idx)) & 32'hF);
    m_dig_en = ~(8'h01 << idx);
    m_seg = glyph[nib];
  endtask

  task automatic tick();
    model_edge();
    @(posedge cpu_clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic drive(input bit rst, input logic [31:0] a, input bit w, input logic [31:0] d);
    logic [31:0] dr;
    dr = $urandom;
    cpu_rst = rst; addr_from_cpu = a; wen_from_cpu = w; wdata_from_cpu = d; dram_rdata = dr;
    push(0, model_read(a, dr), "rdata");
    push(1, m_led32, "led");
    push(2, {24'h0, m_dig_en}, "dig_en");
    push(3, {24'h0, m_seg}, "seg");
    push(4, {31'h0, (w && (a[31:12] != 20'hFFFFF))}, "dram_we");
    push(5, {18'h0, a[15:2]}, "dram_addr");
    push(6, d, "dram_wdata");
    tick();
  endtask

  logic [11:0] offs [7] = '{12'h000, 12'h020, 12'h060, 12'h070, 12'h078, 12'h044, 12'hFFC};

  initial begin
    logic [31:0] a;
    cpu_rst = 1'b0; addr_from_cpu = 0; wen_from_cpu = 0; wdata_from_cpu = 0;
    dram_rdata = 0; sw = 0; button = 0;
    tick();
    for (int i = 0; i < 3; i++) drive(0, 32'hFFFF_F020, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 32'hFFFF_F020, 0, 0);
    drive(1, 32'hFFFF_F020, 1, 32'h5A5A_0000);
    for (int i = 0; i < 4; i++) drive(1, 32'hFFFF_F020, 0, 0);
    drive(1, 32'hFFFF_F020, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) drive(1, 32'hFFFF_F020, 0, 0);
    drive(1, 32'h0000_0100, 1, 32'h1234_5678);
    drive(1, 32'hFFFF_F060, 1, 32'h1234_5678);
    drive(1, 32'hFFFF_F044, 0, 0);
    drive(1, 32'hFFFF_F044, 1, 32'hDEAD_BEEF);
    drive(1, 32'hFFFF_F060, 0, 0);
    drive(1, 32'hFFFF_F000, 1, 32'h0000_00F8);
    for (int i = 0; i < 40; i++) drive(1, 32'hFFFF_F000, 0, 0);
    sw = 24'hABCDEF; button = 5'b10001;
    for (int i = 0; i < 3; i++) drive(1, 32'hFFFF_F070, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'hFFFF_F078, 0, 0);
    drive(0, 32'hFFFF_F060, 1, 32'h00FF_FFFF);
    drive(1, 32'hFFFF_F060, 0, 0);
    drive(1, 32'hFFFF_F000, 1, 32'h7654_3210);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        a = $urandom;
        if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
      end else begin
        a = {20'hFFFFF, offs[$urandom_range(0, 6)]};
      end
      if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 7) == 0) button = 5'($urandom);
      drive($urandom_range(0, 79) != 0, a, $urandom_range(0, 2) == 0, $urandom);
    end
    cpu_rst = 1'b1; wen_from_cpu = 1'b0;
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge cpu_clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
